// File: rtl/branch_unit_bht.sv
`timescale 1ns/1ps
// Branch resolution unit with a table of 2-bit saturating direction counters.
// Fetch looks up a prediction; execute resolves the branch, computes the next PC,
// raises a flush on mispredict and trains the counter for that PC.
module branch_unit_bht #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    // Fetch-side lookup
    input  logic                 pred_valid,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    output logic                 pred_ready,
    output logic                 pred_taken,
    // Execute-side resolution
    input  logic                 res_valid,
    input  logic [2:0]           res_cond,
    input  logic [WIDTH-1:0]     res_op_a,
    input  logic [WIDTH-1:0]     res_op_b,
    input  logic [PC_WIDTH-1:0]  res_pc,
    input  logic [PC_WIDTH-1:0]  res_offset,
    input  logic                 res_predicted,
    output logic                 res_done,
    output logic                 branch_taken,
    output logic [PC_WIDTH-1:0]  branch_target,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        CondEq     = 3'b000,
        CondNe     = 3'b001,
        CondLt     = 3'b010,
        CondGe     = 3'b011,
        CondLtu    = 3'b100,
        CondGeu    = 3'b101,
        CondAlways = 3'b110,
        CondNever  = 3'b111
    } cond_e;

    // Weakly not-taken is the reset value of every counter.
    localparam logic [1:0] CtrInit = 2'b01;

    // Table indices: word-aligned PCs, so bits [1:0] carry no information.
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             unused_pc_bits;

    assign pred_idx       = pred_pc[IDX_W+1:2];
    assign res_idx        = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc, res_pc};

    // State
    logic [1:0]           bht_q [BHT_DEPTH];
    logic [1:0]           bht_d [BHT_DEPTH];
    logic                 pred_ready_q, pred_ready_d;
    logic                 pred_taken_q, pred_taken_d;
    logic                 res_done_q, res_done_d;
    logic                 branch_taken_q, branch_taken_d;
    logic [PC_WIDTH-1:0]  branch_target_q, branch_target_d;
    logic                 flush_q, flush_d;
    logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;

    // Condition evaluation and derived next-PC values
    logic                cond_taken;
    logic                mispredict;
    logic [PC_WIDTH-1:0] target_taken;
    logic [PC_WIDTH-1:0] target_fallthru;
    logic [1:0]          res_ctr;
    logic [1:0]          res_ctr_next;

    // Evaluate the requested branch condition on the two operands.
    always_comb begin
        cond_taken = 1'b0;
        unique case (cond_e'(res_cond))
            CondEq:     cond_taken = (res_op_a == res_op_b);
            CondNe:     cond_taken = (res_op_a != res_op_b);
            CondLt:     cond_taken = ($signed(res_op_a) <  $signed(res_op_b));
            CondGe:     cond_taken = ($signed(res_op_a) >= $signed(res_op_b));
            CondLtu:    cond_taken = (res_op_a <  res_op_b);
            CondGeu:    cond_taken = (res_op_a >= res_op_b);
            CondAlways: cond_taken = 1'b1;
            CondNever:  cond_taken = 1'b0;
            default:    cond_taken = 1'b0;
        endcase
    end

    // Both candidate next PCs wrap modulo 2^PC_WIDTH.
    always_comb begin
        target_taken    = res_pc + res_offset;
        target_fallthru = res_pc + PC_WIDTH'(4);
        mispredict      = (cond_taken != res_predicted);
    end

    // Saturating counter step for the resolved branch's table entry.
    always_comb begin
        res_ctr      = bht_q[res_idx];
        res_ctr_next = res_ctr;
        if (cond_taken) begin
            if (res_ctr != 2'b11) begin
                res_ctr_next = res_ctr + 2'b01;
            end
        end else begin
            if (res_ctr != 2'b00) begin
                res_ctr_next = res_ctr - 2'b01;
            end
        end
    end

    // Table next state; NEVER branches carry no direction information.
    always_comb begin
        bht_d = bht_q;
        if (res_valid && (cond_e'(res_cond) != CondNever)) begin
            bht_d[res_idx] = res_ctr_next;
        end
    end

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    always_comb begin
        pred_ready_d = pred_valid;
        pred_taken_d = 1'b0;
        if (pred_valid) begin
            pred_taken_d = bht_q[pred_idx][1];
        end
    end

    // Resolution outputs; the target holds between resolutions.
    always_comb begin
        res_done_d      = 1'b0;
        branch_taken_d  = 1'b0;
        flush_d         = 1'b0;
        branch_target_d = branch_target_q;
        if (res_valid) begin
            res_done_d      = 1'b1;
            branch_taken_d  = cond_taken;
            flush_d         = mispredict;
            branch_target_d = cond_taken ? target_taken : target_fallthru;
        end
    end

    // Mispredict total, saturating at all-ones.
    always_comb begin
        mispred_count_d = mispred_count_q;
        if (res_valid && mispredict && (mispred_count_q != {CNT_WIDTH{1'b1}})) begin
            mispred_count_d = mispred_count_q + CNT_WIDTH'(1);
        end
    end

    // Direction counter table.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CtrInit;
            end
        end else begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    // Prediction and resolution output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pred_ready_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            res_done_q      <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            flush_q         <= 1'b0;
            mispred_count_q <= '0;
        end else begin
            pred_ready_q    <= pred_ready_d;
            pred_taken_q    <= pred_taken_d;
            res_done_q      <= res_done_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            flush_q         <= flush_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign pred_ready    = pred_ready_q;
    assign pred_taken    = pred_taken_q;
    assign res_done      = res_done_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign flush         = flush_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
`timescale 1ns/1ps
// Directed bench for branch_unit_bht: each task drives one scenario and checks inline.
module tb_branch_unit_bht;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_ready;
    logic        pred_taken;
    logic        res_valid = 1'b0;
    logic [2:0]  res_cond = '0;
    logic [31:0] res_op_a = '0;
    logic [31:0] res_op_b = '0;
    logic [31:0] res_pc = '0;
    logic [31:0] res_offset = '0;
    logic        res_predicted = 1'b0;
    logic        res_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        flush;
    logic [15:0] mispred_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_mis = '0;

    always #5 clock = ~clock;

    branch_unit_bht dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_ready    (pred_ready),
        .pred_taken    (pred_taken),
        .res_valid     (res_valid),
        .res_cond      (res_cond),
        .res_op_a      (res_op_a),
        .res_op_b      (res_op_b),
        .res_pc        (res_pc),
        .res_offset    (res_offset),
        .res_predicted (res_predicted),
        .res_done      (res_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .flush         (flush),
        .mispred_count (mispred_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off, input logic p);
        res_valid     = 1'b1;
        res_cond      = c;
        res_op_a      = a;
        res_op_b      = b;
        res_pc        = pc;
        res_offset    = off;
        res_predicted = p;
    endtask

    task automatic clear_inputs();
        res_valid  = 1'b0;
        pred_valid = 1'b0;
        pred_pc    = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        exp_mis = '0;
    endtask

    // One resolution cycle, then idle.
    task automatic do_resolve(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] off, input logic p);
        set_res(c, a, b, pc, off, p);
        step();
        res_valid = 1'b0;
    endtask

    // One lookup cycle; returns what the DUT showed after the edge.
    task automatic do_lookup(input logic [31:0] pc, output logic rdy, output logic tk);
        pred_valid = 1'b1;
        pred_pc    = pc;
        step();
        rdy        = pred_ready;
        tk         = pred_taken;
        pred_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic rdy, tk;
        step();
        total++;
        if ({pred_ready, pred_taken, res_done, branch_taken, flush} !== 5'b0 ||
            branch_target !== 32'h0 || mispred_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_hold: outputs %b tgt=%h cnt=%h, want all 0",
                     {pred_ready, pred_taken, res_done, branch_taken, flush},
                     branch_target, mispred_count);
        end
        reset_n = 1'b1;
        pred_valid = 1'b1;
        pred_pc = 32'h40;
        set_res(3'b110, 32'h0, 32'h0, 32'h10, 32'h8, 1'b0);
        step();
        total++;
        if (res_done !== 1'b1 || flush !== 1'b1 || branch_target !== 32'h18) begin
            bad++;
            $display("FAIL pre_reset_res: done=%b flush=%b tgt=%h, want 1 1 00000018",
                     res_done, flush, branch_target);
        end
        // Async reset in the middle of the cycle.
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({pred_ready, pred_taken, res_done, branch_taken, flush} !== 5'b0 ||
            branch_target !== 32'h0 || mispred_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_async: outputs %b tgt=%h cnt=%h, want all 0",
                     {pred_ready, pred_taken, res_done, branch_taken, flush},
                     branch_target, mispred_count);
        end
        clear_inputs();
        step();
        reset_n = 1'b1;
        step();
        total++;
        if (res_done !== 1'b0 || flush !== 1'b0 || pred_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: done=%b flush=%b rdy=%b, want 0 0 0",
                     res_done, flush, pred_ready);
        end
        do_lookup(32'h40, rdy, tk);
        total++;
        if (rdy !== 1'b1 || tk !== 1'b0 || mispred_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_lookup: rdy=%b taken=%b cnt=%h, want 1 0 0000", rdy, tk,
                     mispred_count);
        end
        exp_mis = '0;
    endtask

    task automatic test_beq();
        do_resolve(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        exp_mis = 16'd1;
        total++;
        if (res_done !== 1'b1 || branch_taken !== 1'b1 || branch_target !== 32'h120 ||
            flush !== 1'b1 || mispred_count !== exp_mis) begin
            bad++;
            $display("FAIL beq: done=%b tk=%b tgt=%h flush=%b cnt=%0d, want 1 1 00000120 1 %0d",
                     res_done, branch_taken, branch_target, flush, mispred_count, exp_mis);
        end
        step();
        total++;
        if (res_done !== 1'b0 || branch_taken !== 1'b0 || flush !== 1'b0 ||
            branch_target !== 32'h120 || mispred_count !== exp_mis) begin
            bad++;
            $display("FAIL beq_idle: done=%b tk=%b flush=%b tgt=%h cnt=%0d, want 0 0 0 120 %0d",
                     res_done, branch_taken, flush, branch_target, mispred_count, exp_mis);
        end
    endtask

    // All eight conditions, back-to-back, predicted not-taken so flush equals taken.
    task automatic test_conditions();
        logic [2:0]  c   [13];
        logic [31:0] a   [13];
        logic [31:0] b   [13];
        logic        exp [13];
        c[0]  = 3'd0; a[0]  = 32'hFFFF_FFFF; b[0]  = 32'd1; exp[0]  = 1'b0;
        c[1]  = 3'd1; a[1]  = 32'hFFFF_FFFF; b[1]  = 32'd1; exp[1]  = 1'b1;
        c[2]  = 3'd2; a[2]  = 32'hFFFF_FFFF; b[2]  = 32'd1; exp[2]  = 1'b1;
        c[3]  = 3'd3; a[3]  = 32'hFFFF_FFFF; b[3]  = 32'd1; exp[3]  = 1'b0;
        c[4]  = 3'd4; a[4]  = 32'hFFFF_FFFF; b[4]  = 32'd1; exp[4]  = 1'b0;
        c[5]  = 3'd5; a[5]  = 32'hFFFF_FFFF; b[5]  = 32'd1; exp[5]  = 1'b1;
        c[6]  = 3'd6; a[6]  = 32'hFFFF_FFFF; b[6]  = 32'd1; exp[6]  = 1'b1;
        c[7]  = 3'd7; a[7]  = 32'hFFFF_FFFF; b[7]  = 32'd1; exp[7]  = 1'b0;
        c[8]  = 3'd2; a[8]  = 32'd5;         b[8]  = 32'd5; exp[8]  = 1'b0;
        c[9]  = 3'd3; a[9]  = 32'd5;         b[9]  = 32'd5; exp[9]  = 1'b1;
        c[10] = 3'd4; a[10] = 32'd5;         b[10] = 32'd5; exp[10] = 1'b0;
        c[11] = 3'd5; a[11] = 32'd5;         b[11] = 32'd5; exp[11] = 1'b1;
        c[12] = 3'd7; a[12] = 32'd5;         b[12] = 32'd5; exp[12] = 1'b0;
        for (int i = 0; i < 13; i++) begin
            set_res(c[i], a[i], b[i], 32'h104, 32'h20, 1'b0);
            step();
            if (exp[i]) exp_mis = exp_mis + 16'd1;
            total++;
            if (res_done !== 1'b1 || branch_taken !== exp[i] || flush !== exp[i] ||
                branch_target !== (exp[i] ? 32'h124 : 32'h108) || mispred_count !== exp_mis) begin
                bad++;
                $display("FAIL cond_%0d: done=%b tk=%b flush=%b tgt=%h cnt=%0d, want tk=%b cnt=%0d",
                         i, res_done, branch_taken, flush, branch_target, mispred_count,
                         exp[i], exp_mis);
            end
        end
        res_valid = 1'b0;
    endtask

    task automatic test_saturation();
        logic rdy, tk;
        logic exp_up [3];
        logic exp_dn [3];
        exp_up[0] = 1'b1; exp_up[1] = 1'b1; exp_up[2] = 1'b1;
        exp_dn[0] = 1'b1; exp_dn[1] = 1'b0; exp_dn[2] = 1'b0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_resolve(3'b110, 32'h0, 32'h0, 32'h80, 32'h10, 1'b1);
            do_lookup(32'h80, rdy, tk);
            total++;
            if (rdy !== 1'b1 || tk !== exp_up[i]) begin
                bad++;
                $display("FAIL sat_up_%0d: rdy=%b taken=%b, want 1 %b", i, rdy, tk, exp_up[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_resolve(3'b001, 32'h7, 32'h7, 32'h80, 32'h10, 1'b0);
            do_lookup(32'h80, rdy, tk);
            total++;
            if (tk !== exp_dn[i]) begin
                bad++;
                $display("FAIL sat_down_%0d: taken=%b, want %b", i, tk, exp_dn[i]);
            end
        end
        // Extra decrement must hold at 00, so one taken leaves it weakly not-taken.
        do_resolve(3'b001, 32'h7, 32'h7, 32'h80, 32'h10, 1'b0);
        do_resolve(3'b110, 32'h0, 32'h0, 32'h80, 32'h10, 1'b1);
        do_lookup(32'h80, rdy, tk);
        total++;
        if (tk !== 1'b0 || mispred_count !== 16'h0) begin
            bad++;
            $display("FAIL sat_floor: taken=%b cnt=%h, want 0 0000", tk, mispred_count);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        pred_valid = 1'b1;
        pred_pc    = 32'h80;
        set_res(3'b110, 32'h0, 32'h0, 32'h80, 32'h40, 1'b0);
        step();
        res_valid = 1'b0;
        total++;
        if (pred_ready !== 1'b1 || pred_taken !== 1'b0 || flush !== 1'b1) begin
            bad++;
            $display("FAIL collide_same: rdy=%b taken=%b flush=%b, want 1 0 1",
                     pred_ready, pred_taken, flush);
        end
        step();
        pred_valid = 1'b0;
        total++;
        if (pred_ready !== 1'b1 || pred_taken !== 1'b1 || res_done !== 1'b0) begin
            bad++;
            $display("FAIL collide_next: rdy=%b taken=%b done=%b, want 1 1 0",
                     pred_ready, pred_taken, res_done);
        end
    endtask

    // Resolutions every cycle with a lookup of the same PC alongside each.
    task automatic test_back_to_back();
        logic [2:0]  c    [4];
        logic        vld  [4];
        logic        tk_e [4];
        logic        pr_e [4];
        logic [31:0] tg_e [4];
        apply_reset();
        c[0] = 3'd6; vld[0] = 1'b1; tk_e[0] = 1'b1; pr_e[0] = 1'b0; tg_e[0] = 32'h90;
        c[1] = 3'd6; vld[1] = 1'b1; tk_e[1] = 1'b1; pr_e[1] = 1'b1; tg_e[1] = 32'h90;
        c[2] = 3'd1; vld[2] = 1'b1; tk_e[2] = 1'b0; pr_e[2] = 1'b1; tg_e[2] = 32'h84;
        c[3] = 3'd1; vld[3] = 1'b0; tk_e[3] = 1'b0; pr_e[3] = 1'b1; tg_e[3] = 32'h84;
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1;
            pred_pc    = 32'h80;
            set_res(c[i], 32'h3, 32'h3, 32'h80, 32'h10, 1'b0);
            res_valid = vld[i];
            step();
            if (vld[i] && tk_e[i]) exp_mis = exp_mis + 16'd1;
            total++;
            if (res_done !== vld[i] || branch_taken !== tk_e[i] || flush !== tk_e[i] ||
                branch_target !== tg_e[i] || pred_taken !== pr_e[i] ||
                mispred_count !== exp_mis) begin
                bad++;
                $display("FAIL b2b_%0d: done=%b tk=%b flush=%b tgt=%h pred=%b cnt=%0d, want %b %b %b %h %b %0d",
                         i, res_done, branch_taken, flush, branch_target, pred_taken,
                         mispred_count, vld[i], tk_e[i], tk_e[i], tg_e[i], pr_e[i], exp_mis);
            end
        end
        clear_inputs();
    endtask

    task automatic test_wrap_saturate();
        logic rdy, tk;
        apply_reset();
        do_resolve(3'b110, 32'h0, 32'h0, 32'h3C, 32'h4, 1'b1);
        do_lookup(32'hFFFF_FFFC, rdy, tk);
        total++;
        if (tk !== 1'b1) begin
            bad++;
            $display("FAIL wrap_train: taken=%b, want 1", tk);
        end
        do_resolve(3'b111, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h40, 1'b0);
        total++;
        if (branch_taken !== 1'b0 || branch_target !== 32'h0 || flush !== 1'b0) begin
            bad++;
            $display("FAIL wrap_never: tk=%b tgt=%h flush=%b, want 0 00000000 0",
                     branch_taken, branch_target, flush);
        end
        do_lookup(32'hFFFF_FFFC, rdy, tk);
        total++;
        if (tk !== 1'b1) begin
            bad++;
            $display("FAIL never_no_update: taken=%b, want 1", tk);
        end
        do_resolve(3'b110, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 1'b1);
        total++;
        if (branch_target !== 32'h4 || flush !== 1'b0) begin
            bad++;
            $display("FAIL wrap_taken: tgt=%h flush=%b, want 00000004 0", branch_target, flush);
        end
        set_res(3'b110, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (5) step();
        total++;
        if (mispred_count !== 16'd5) begin
            bad++;
            $display("FAIL cnt_mid: cnt=%0d, want 5", mispred_count);
        end
        repeat (65534) step();
        total++;
        if (mispred_count !== 16'hFFFF || flush !== 1'b1) begin
            bad++;
            $display("FAIL cnt_sat: cnt=%h flush=%b, want ffff 1", mispred_count, flush);
        end
        step();
        res_valid = 1'b0;
        total++;
        if (mispred_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL cnt_hold: cnt=%h, want ffff", mispred_count);
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_conditions();
        test_saturation();
        test_collision();
        test_back_to_back();
        test_wrap_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
